locked_reg_access_ctrl: RTL and testbench

Host-side initiator for the bank of lockable configuration registers. It accepts write, lock and read commands over a valid/ready handshake and drives the per-register write strobes, lock strobes and shared write data. It keeps a shadow copy of every register's lock state, refuses writes to locked registers with an error response, and counts refused writes for security telemetry.

---
 rtl/locked_reg_pkg.sv | 28 ++
 rtl/locked_reg_viol_counter.sv | 23 ++
 rtl/locked_reg_access_ctrl.sv | 169 ++++++++++++++++
 tb/tb_locked_reg_access_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/locked_reg_pkg.sv
// Shared encodings and default sizing for the lockable register access controller.
package locked_reg_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_ADDR_W   = 2;
  localparam int DEF_VIOL_W   = 8;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_LOCK  = 2'b01,
    OP_READ  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK     = 2'b00,
    ST_LOCKED = 2'b01,
    ST_BADCMD = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/locked_reg_viol_counter.sv
// Saturating counter of refused writes; holds at all-ones once full.
module locked_reg_viol_counter #(
  parameter int VIOL_W = 8
) (
  input  logic              Clk,
  input  logic              resetn,
  input  logic              i_inc,
  output logic [VIOL_W-1:0] o_count
);

  logic [VIOL_W-1:0] r_count;

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + VIOL_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/locked_reg_access_ctrl.sv
// Host-side initiator for the lockable config register bank with shadow lock tracking.
// Optional macro LOCKED_REG_DEBUG_OVERRIDE_EN lets an authorised debug host write locked registers.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// EXEC  | one-cycle strobe to the bank, response fields captured
// RESP  | rsp_valid high, held until rsp_ready
module locked_reg_access_ctrl
  import locked_reg_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int VIOL_W   = DEF_VIOL_W
) (
  input  logic                       Clk,
  input  logic                       resetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [ADDR_W-1:0]          cmd_addr,
  input  logic [DATA_W-1:0]          cmd_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [1:0]                 rsp_status,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [DATA_W-1:0]          reg_wdata,
  output logic [NUM_REGS-1:0]        reg_write,
  output logic [NUM_REGS-1:0]        reg_lock,
  input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
  input  logic                       scan_mode,
  input  logic                       debug_unlocked,
  output logic [NUM_REGS-1:0]        lock_shadow,
  output logic [VIOL_W-1:0]          viol_count
);

  state_e                r_state, w_next_state;
  logic [1:0]            r_op;
  logic [ADDR_W-1:0]     r_addr;
  logic [1:0]            r_pend_status;
  logic                  r_pend_viol;
  logic                  r_cmd_ready, r_rsp_valid;
  logic [1:0]            r_rsp_status;
  logic [DATA_W-1:0]     r_rsp_data, r_reg_wdata;
  logic [NUM_REGS-1:0]   r_reg_write, r_reg_lock, r_lock_shadow;

  logic                  w_accept, w_override, w_addr_ok, w_locked, w_viol_inc;
  logic                  w_cmd_ready_nxt, w_rsp_valid_nxt, w_viol_nxt;
  logic [1:0]            w_status_nxt;
  logic [NUM_REGS-1:0]   w_sel, w_write_nxt, w_lock_nxt;
  logic [DATA_W-1:0]     w_rd_slice;

`ifdef LOCKED_REG_DEBUG_OVERRIDE_EN
  assign w_override = debug_unlocked & ~scan_mode;
`else
  logic w_unused_dbg;
  assign w_override   = 1'b0;
  assign w_unused_dbg = debug_unlocked ^ scan_mode;
`endif

  assign w_accept = (r_state == S_IDLE) && cmd_valid;

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_ready_nxt = (w_next_state == S_IDLE);
    w_rsp_valid_nxt = (w_next_state == S_RESP);
  end

  // Decode happens on the accepting edge so the bank strobe lands in the EXEC cycle.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) w_sel[i] = (cmd_addr == ADDR_W'(i));
    w_addr_ok    = |w_sel;
    w_locked     = |(w_sel & r_lock_shadow);
    w_write_nxt  = '0;
    w_lock_nxt   = '0;
    w_status_nxt = ST_OK;
    w_viol_nxt   = 1'b0;
    if (!w_addr_ok || (cmd_op == OP_RSVD)) begin
      w_status_nxt = ST_BADCMD;
    end else if (cmd_op == OP_WRITE) begin
      if (!w_locked || w_override) begin
        w_write_nxt = w_sel;
      end else begin
        w_status_nxt = ST_LOCKED;
        w_viol_nxt   = 1'b1;
      end
    end else if (cmd_op == OP_LOCK) begin
      w_lock_nxt = w_sel;
    end
  end

  always_comb begin
    w_rd_slice = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_addr == ADDR_W'(i)) w_rd_slice = reg_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_status  <= ST_OK;
      r_rsp_data    <= '0;
      r_reg_wdata   <= '0;
      r_reg_write   <= '0;
      r_reg_lock    <= '0;
      r_lock_shadow <= '0;
      r_op          <= OP_WRITE;
      r_addr        <= '0;
      r_pend_status <= ST_OK;
      r_pend_viol   <= 1'b0;
    end else begin
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_reg_write   <= w_accept ? w_write_nxt : '0;
      r_reg_lock    <= w_accept ? w_lock_nxt  : '0;
      r_lock_shadow <= r_lock_shadow | r_reg_lock;
      if (w_accept) begin
        r_op          <= cmd_op;
        r_addr        <= cmd_addr;
        r_pend_status <= w_status_nxt;
        r_pend_viol   <= w_viol_nxt;
        if (|w_write_nxt) r_reg_wdata <= cmd_data;
      end
      if (r_state == S_EXEC) begin
        r_rsp_status <= r_pend_status;
        r_rsp_data   <= ((r_op == OP_READ) && (r_pend_status == ST_OK)) ? w_rd_slice : '0;
      end else if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_status <= ST_OK;
        r_rsp_data   <= '0;
      end
    end
  end

  assign w_viol_inc = (r_state == S_EXEC) && r_pend_viol;

  locked_reg_viol_counter #(.VIOL_W(VIOL_W)) u_viol_counter (
    .Clk     (Clk),
    .resetn  (resetn),
    .i_inc   (w_viol_inc),
    .o_count (viol_count)
  );

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_status  = r_rsp_status;
  assign rsp_data    = r_rsp_data;
  assign reg_wdata   = r_reg_wdata;
  assign reg_write   = r_reg_write;
  assign reg_lock    = r_reg_lock;
  assign lock_shadow = r_lock_shadow;

endmodule

// File: tb/tb_locked_reg_access_ctrl.sv
// Bench for locked_reg_access_ctrl: a 4-register and a 3-register instance run the same
// command stream in lockstep and are compared against a spec-level model.
module tb_locked_reg_access_ctrl;

  logic        Clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [1:0]  cmd_addr = 2'b00;
  logic [15:0] cmd_data = 16'h0;
  logic        rsp_ready = 1'b0;
  logic        scan_mode = 1'b0;
  logic        debug_unlocked = 1'b0;
  logic [63:0] reg_rdata = 64'h0;

  always #5 Clk = ~Clk;

  logic        cmd_ready_a, rsp_valid_a, cmd_ready_b, rsp_valid_b;
  logic [1:0]  rsp_status_a, rsp_status_b;
  logic [15:0] rsp_data_a, reg_wdata_a, rsp_data_b, reg_wdata_b;
  logic [3:0]  reg_write_a, reg_lock_a, lock_shadow_a;
  logic [2:0]  reg_write_b, reg_lock_b, lock_shadow_b;
  logic [7:0]  viol_count_a, viol_count_b;

  locked_reg_access_ctrl dut_a (
    .Clk(Clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_status(rsp_status_a),
    .rsp_data(rsp_data_a), .reg_wdata(reg_wdata_a), .reg_write(reg_write_a),
    .reg_lock(reg_lock_a), .reg_rdata(reg_rdata), .scan_mode(scan_mode),
    .debug_unlocked(debug_unlocked), .lock_shadow(lock_shadow_a), .viol_count(viol_count_a)
  );

  locked_reg_access_ctrl #(.NUM_REGS(3)) dut_b (
    .Clk(Clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_status(rsp_status_b),
    .rsp_data(rsp_data_b), .reg_wdata(reg_wdata_b), .reg_write(reg_write_b),
    .reg_lock(reg_lock_b), .reg_rdata(reg_rdata[47:0]), .scan_mode(scan_mode),
    .debug_unlocked(debug_unlocked), .lock_shadow(lock_shadow_b), .viol_count(viol_count_b)
  );

  logic        cr_v [2];
  logic        rv_v [2];
  logic [1:0]  rs_v [2];
  logic [15:0] rd_v [2];
  logic [15:0] wd_v [2];
  logic [3:0]  wr_v [2];
  logic [3:0]  lk_v [2];
  logic [3:0]  sh_v [2];
  logic [7:0]  vc_v [2];

  assign cr_v[0] = cmd_ready_a;    assign cr_v[1] = cmd_ready_b;
  assign rv_v[0] = rsp_valid_a;    assign rv_v[1] = rsp_valid_b;
  assign rs_v[0] = rsp_status_a;   assign rs_v[1] = rsp_status_b;
  assign rd_v[0] = rsp_data_a;     assign rd_v[1] = rsp_data_b;
  assign wd_v[0] = reg_wdata_a;    assign wd_v[1] = reg_wdata_b;
  assign wr_v[0] = reg_write_a;    assign wr_v[1] = {1'b0, reg_write_b};
  assign lk_v[0] = reg_lock_a;     assign lk_v[1] = {1'b0, reg_lock_b};
  assign sh_v[0] = lock_shadow_a;  assign sh_v[1] = {1'b0, lock_shadow_b};
  assign vc_v[0] = viol_count_a;   assign vc_v[1] = viol_count_b;

  typedef struct {
    logic [3:0]  wr_or, lk_or;
    int          wr_cnt, lk_cnt, wr_cyc, lk_cyc, rsp_cyc;
    logic [15:0] wdata, data;
    logic [1:0]  status;
    bit          both, unstable, early_ready, timeout;
  } obs_t;

  typedef struct {
    logic [3:0]  wr, lk, shadow;
    logic [15:0] wdata, data;
    logic [1:0]  status;
    int          viol;
  } exp_t;

  obs_t o [2];
  exp_t e [2];
  bit   m_lock [2][4];
  int   m_viol [2];
  int   NR [2] = '{4, 3};
  int   n_checks = 0;
  int   n_pass = 0;

  // Spec-level reference: lock rules, violation saturation, read slice selection.
  task automatic model_apply(input logic [1:0] op, input logic [1:0] addr, input logic [15:0] data);
    logic [63:0] rd;
    rd = reg_rdata;
    for (int w = 0; w < 2; w++) begin
      bit ovr;
      ovr = 1'b0;
`ifdef LOCKED_REG_DEBUG_OVERRIDE_EN
      ovr = debug_unlocked && !scan_mode;
`endif
      e[w] = '{default: 0};
      if (op == 2'b11 || int'(addr) >= NR[w]) begin
        e[w].status = 2'b10;
      end else if (op == 2'b00) begin
        if (!m_lock[w][addr] || ovr) begin
          e[w].wr    = 4'b0001 << addr;
          e[w].wdata = data;
        end else begin
          e[w].status = 2'b01;
          if (m_viol[w] < 255) m_viol[w]++;
        end
      end else if (op == 2'b01) begin
        e[w].lk = 4'b0001 << addr;
        m_lock[w][addr] = 1'b1;
      end else begin
        e[w].data = rd[int'(addr)*16 +: 16];
      end
      e[w].viol = m_viol[w];
      for (int i = 0; i < 4; i++) e[w].shadow[i] = m_lock[w][i];
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_viol[w] = 0;
      for (int i = 0; i < 4; i++) m_lock[w][i] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge Clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [1:0] addr, input logic [15:0] data, input int hold);
    int guard;
    bit done;
    for (int w = 0; w < 2; w++) o[w] = '{default: 0};
    @(negedge Clk);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    guard = 0;
    while (!(cr_v[0] && cr_v[1]) && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 20) begin
      cmd_valid = 1'b0;
      o[0].timeout = 1'b1;
      o[1].timeout = 1'b1;
      return;
    end
    @(posedge Clk);
    #1 cmd_valid = 1'b0;
    cmd_data = 16'($urandom);
    done = 1'b0;
    for (int cyc = 1; cyc <= 30 && !done; cyc++) begin
      @(negedge Clk);
      for (int w = 0; w < 2; w++) begin
        if (wr_v[w] != 0) begin
          o[w].wr_cnt++; o[w].wr_or |= wr_v[w]; o[w].wr_cyc = cyc; o[w].wdata = wd_v[w];
        end
        if (lk_v[w] != 0) begin
          o[w].lk_cnt++; o[w].lk_or |= lk_v[w]; o[w].lk_cyc = cyc;
        end
        if (wr_v[w] != 0 && lk_v[w] != 0) o[w].both = 1'b1;
        if (cr_v[w]) o[w].early_ready = 1'b1;
        if (o[w].rsp_cyc == 0) begin
          if (rv_v[w]) begin
            o[w].rsp_cyc = cyc; o[w].status = rs_v[w]; o[w].data = rd_v[w];
          end
        end else if (!rv_v[w] || rs_v[w] != o[w].status || rd_v[w] != o[w].data) begin
          o[w].unstable = 1'b1;
        end
      end
      if (o[0].rsp_cyc != 0 && o[1].rsp_cyc != 0 && cyc >= o[0].rsp_cyc + hold) begin
        rsp_ready = 1'b1;
        @(posedge Clk);
        #1 rsp_ready = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      o[0].timeout = 1'b1;
      o[1].timeout = 1'b1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge Clk);
    n_checks++; if (cmd_ready_a !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready_a); else n_pass++;
    n_checks++; if (cmd_ready_b !== 1'b1) $display("FAIL reset_cmd_ready_b got %b want 1", cmd_ready_b); else n_pass++;
    n_checks++; if (rsp_valid_a !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_a); else n_pass++;
    n_checks++; if ({reg_write_a, reg_lock_a} !== 8'h00) $display("FAIL reset_strobes got %h want 00", {reg_write_a, reg_lock_a}); else n_pass++;
    n_checks++; if (lock_shadow_a !== 4'h0) $display("FAIL reset_shadow got %h want 0", lock_shadow_a); else n_pass++;
    n_checks++; if (viol_count_a !== 8'h00) $display("FAIL reset_viol got %h want 00", viol_count_a); else n_pass++;
    n_checks++; if ({rsp_status_a, rsp_data_a, reg_wdata_a} !== 34'h0) $display("FAIL reset_rsp_fields got %h want 0", {rsp_status_a, rsp_data_a, reg_wdata_a}); else n_pass++;
  endtask

  task automatic test_write_basic();
    model_apply(2'b00, 2'd1, 16'hA5A5);
    run_cmd(2'b00, 2'd1, 16'hA5A5, 0);
    n_checks++; if (o[0].wr_or !== 4'b0010 || o[0].wr_cnt != 1) $display("FAIL write_strobe got %b x%0d want 0010 x1", o[0].wr_or, o[0].wr_cnt); else n_pass++;
    n_checks++; if (o[0].wr_cyc != 1) $display("FAIL write_strobe_cycle got %0d want 1", o[0].wr_cyc); else n_pass++;
    n_checks++; if (o[0].wdata !== 16'hA5A5) $display("FAIL write_wdata got %h want a5a5", o[0].wdata); else n_pass++;
    n_checks++; if (o[0].status !== 2'b00 || o[0].rsp_cyc != 2) $display("FAIL write_rsp got st=%b cyc=%0d want st=00 cyc=2", o[0].status, o[0].rsp_cyc); else n_pass++;
    n_checks++; if (viol_count_a !== 8'h00) $display("FAIL write_viol got %h want 00", viol_count_a); else n_pass++;
  endtask

  task automatic test_lock_then_write();
    model_apply(2'b01, 2'd1, 16'h0);
    run_cmd(2'b01, 2'd1, 16'h0, 0);
    n_checks++; if (o[0].lk_or !== 4'b0010 || o[0].lk_cnt != 1 || o[0].lk_cyc != 1) $display("FAIL lock_strobe got %b x%0d at %0d want 0010 x1 at 1", o[0].lk_or, o[0].lk_cnt, o[0].lk_cyc); else n_pass++;
    n_checks++; if (o[0].wr_cnt != 0 || o[0].status !== 2'b00) $display("FAIL lock_rsp got wr=%0d st=%b want wr=0 st=00", o[0].wr_cnt, o[0].status); else n_pass++;
    n_checks++; if (lock_shadow_a !== 4'b0010) $display("FAIL lock_shadow got %b want 0010", lock_shadow_a); else n_pass++;
    model_apply(2'b00, 2'd1, 16'h1234);
    run_cmd(2'b00, 2'd1, 16'h1234, 0);
    n_checks++; if (o[0].wr_cnt != 0 || o[0].status !== 2'b01) $display("FAIL locked_write got wr=%0d st=%b want wr=0 st=01", o[0].wr_cnt, o[0].status); else n_pass++;
    n_checks++; if (viol_count_a !== 8'h01) $display("FAIL locked_write_viol got %h want 01", viol_count_a); else n_pass++;
  endtask

  task automatic test_scan_override();
    model_apply(2'b01, 2'd2, 16'h0);
    run_cmd(2'b01, 2'd2, 16'h0, 0);
    scan_mode = 1'b1; debug_unlocked = 1'b1;
    model_apply(2'b00, 2'd2, 16'h5555);
    run_cmd(2'b00, 2'd2, 16'h5555, 0);
    n_checks++; if (o[0].wr_cnt != 0 || o[0].status !== 2'b01) $display("FAIL scan_write got wr=%0d st=%b want wr=0 st=01", o[0].wr_cnt, o[0].status); else n_pass++;
    scan_mode = 1'b0;
    model_apply(2'b00, 2'd2, 16'h6666);
    run_cmd(2'b00, 2'd2, 16'h6666, 0);
    n_checks++; if (o[0].status !== e[0].status || o[0].wr_or !== e[0].wr) $display("FAIL debug_write got st=%b wr=%b want st=%b wr=%b", o[0].status, o[0].wr_or, e[0].status, e[0].wr); else n_pass++;
    n_checks++; if (int'(viol_count_a) != e[0].viol) $display("FAIL debug_write_viol got %0d want %0d", viol_count_a, e[0].viol); else n_pass++;
    debug_unlocked = 1'b0;
  endtask

  task automatic test_read_hold();
    reg_rdata = {16'hBEEF, 16'($urandom), 16'($urandom), 16'($urandom)};
    model_apply(2'b10, 2'd3, 16'h0);
    run_cmd(2'b10, 2'd3, 16'h0, 5);
    n_checks++; if (o[0].data !== 16'hBEEF || o[0].status !== 2'b00) $display("FAIL read_beef got %h st=%b want beef st=00", o[0].data, o[0].status); else n_pass++;
    n_checks++; if (o[0].unstable || o[0].early_ready) $display("FAIL read_hold got unstable=%0d ready=%0d want 0 0", o[0].unstable, o[0].early_ready); else n_pass++;
    n_checks++; if (o[1].status !== 2'b10 || o[1].data !== 16'h0) $display("FAIL read_badaddr_b got st=%b d=%h want st=10 d=0", o[1].status, o[1].data); else n_pass++;
  endtask

  task automatic test_badcmd();
    model_apply(2'b00, 2'd3, 16'h7777);
    run_cmd(2'b00, 2'd3, 16'h7777, 0);
    n_checks++; if (o[1].status !== 2'b10 || o[1].wr_cnt != 0 || o[1].lk_cnt != 0) $display("FAIL bad_addr_b got st=%b wr=%0d lk=%0d want st=10 0 0", o[1].status, o[1].wr_cnt, o[1].lk_cnt); else n_pass++;
    n_checks++; if (o[0].status !== e[0].status || o[0].wr_or !== e[0].wr) $display("FAIL bad_addr_a got st=%b wr=%b want st=%b wr=%b", o[0].status, o[0].wr_or, e[0].status, e[0].wr); else n_pass++;
    model_apply(2'b11, 2'd0, 16'h0);
    run_cmd(2'b11, 2'd0, 16'h0, 0);
    for (int w = 0; w < 2; w++) begin
      n_checks++; if (o[w].status !== 2'b10 || o[w].wr_cnt != 0 || o[w].lk_cnt != 0) $display("FAIL bad_op dut%0d got st=%b wr=%0d lk=%0d want st=10 0 0", w, o[w].status, o[w].wr_cnt, o[w].lk_cnt); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 80; it++) begin
      logic [1:0] op, addr;
      logic [15:0] data;
      int r;
      r = int'($urandom_range(0, 11));
      op = (r < 4) ? 2'b00 : (r < 5) ? 2'b01 : (r < 10) ? 2'b10 : 2'b11;
      addr = 2'($urandom_range(0, 3));
      data = 16'($urandom);
      scan_mode = 1'($urandom);
      debug_unlocked = 1'($urandom);
      reg_rdata = {$urandom, $urandom};
      model_apply(op, addr, data);
      run_cmd(op, addr, data, int'($urandom_range(0, 2)));
      for (int w = 0; w < 2; w++) begin
        n_checks++;
        if (o[w].timeout || o[w].status !== e[w].status || o[w].data !== e[w].data || o[w].rsp_cyc != 2 || o[w].unstable)
          $display("FAIL rand_rsp it%0d dut%0d got st=%b d=%h cyc=%0d to=%0d want st=%b d=%h cyc=2", it, w, o[w].status, o[w].data, o[w].rsp_cyc, o[w].timeout, e[w].status, e[w].data);
        else n_pass++;
        n_checks++;
        if (o[w].wr_or !== e[w].wr || o[w].lk_or !== e[w].lk || o[w].wr_cnt > 1 || o[w].lk_cnt > 1 || o[w].both ||
            (e[w].wr != 0 && (o[w].wdata !== e[w].wdata || o[w].wr_cyc != 1)))
          $display("FAIL rand_strobe it%0d dut%0d got wr=%b lk=%b wd=%h want wr=%b lk=%b wd=%h", it, w, o[w].wr_or, o[w].lk_or, o[w].wdata, e[w].wr, e[w].lk, e[w].wdata);
        else n_pass++;
        n_checks++;
        if (sh_v[w] !== e[w].shadow || int'(vc_v[w]) != e[w].viol)
          $display("FAIL rand_state it%0d dut%0d got sh=%b v=%0d want sh=%b v=%0d", it, w, sh_v[w], vc_v[w], e[w].shadow, e[w].viol);
        else n_pass++;
      end
    end
    scan_mode = 1'b0;
    debug_unlocked = 1'b0;
  endtask

  task automatic test_saturation();
    model_apply(2'b01, 2'd0, 16'h0);
    run_cmd(2'b01, 2'd0, 16'h0, 0);
    for (int i = 0; i < 260; i++) begin
      scan_mode = 1'($urandom);
      model_apply(2'b00, 2'd0, 16'($urandom));
      run_cmd(2'b00, 2'd0, cmd_data, 0);
      if (i == 5) begin
        n_checks++; if (int'(viol_count_a) != e[0].viol) $display("FAIL sat_mid got %0d want %0d", viol_count_a, e[0].viol); else n_pass++;
      end
    end
    scan_mode = 1'b0;
    n_checks++; if (viol_count_a !== 8'hFF) $display("FAIL sat_a got %h want ff", viol_count_a); else n_pass++;
    n_checks++; if (viol_count_b !== 8'hFF) $display("FAIL sat_b got %h want ff", viol_count_b); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    bit saw_rsp;
    apply_reset();
    @(negedge Clk);
    cmd_op = 2'b01; cmd_addr = 2'd2; cmd_valid = 1'b1;
    @(posedge Clk);
    #1 cmd_valid = 1'b0;
    @(negedge Clk);
    n_checks++; if (reg_lock_a !== 4'b0100) $display("FAIL mid_lock_strobe got %b want 0100", reg_lock_a); else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++; if (cmd_ready_a !== 1'b1 || rsp_valid_a !== 1'b0 || reg_lock_a !== 4'b0) $display("FAIL mid_reset_outs got rdy=%b v=%b lk=%b want 1 0 0000", cmd_ready_a, rsp_valid_a, reg_lock_a); else n_pass++;
    @(negedge Clk);
    resetn = 1'b1;
    model_reset();
    saw_rsp = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      if (rsp_valid_a) saw_rsp = 1'b1;
    end
    n_checks++; if (saw_rsp) $display("FAIL mid_no_rsp got rsp_valid=1 want 0"); else n_pass++;
    n_checks++; if (lock_shadow_a !== 4'b0 || cmd_ready_a !== 1'b1) $display("FAIL mid_state got sh=%b rdy=%b want 0000 1", lock_shadow_a, cmd_ready_a); else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_write_basic();
    test_lock_then_write();
    test_scan_override();
    test_read_hold();
    test_badcmd();
    test_random();
    test_saturation();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
